apb_xfer_sequencer: RTL and testbench
=====================================

// Module: apb_xfer_sequencer
// PURPOSE
//  PCLK-domain controller that drains the CDC request/response mailbox and sequences APB transfers.
//  Accepts one mailbox request at a time and decodes p_req_sel to one of NSLV slaves.
//  Runs SETUP/ACCESS with a PREADY timeout and returns rdata plus a 2-bit error code to the mailbox.
//  Sits between the mailbox PCLK side and the APB slave fabric.
// PARAMETERS
//  ADDR_W    32  APB address width
//  DATA_W    32  APB data width
//  SEL_W     3   width of p_req_sel
//  NSLV      4   number of APB slaves; sel >= NSLV is a decode error
//  TIMEOUT   256 max ACCESS cycles waiting for PREADY; 0 = wait forever
//  RESP_HOLD 6   idle cycles after a response before the next accept (mailbox resp-ack round trip)
// PORTS
//  pclk         in  1            APB clock; single clock for the block
//  preset       in  1            asynchronous reset, active-high
//  p_req_valid  in  1            mailbox has a pending request
//  p_req_accept out 1            combinational; takes the request (mailbox payload valid next cycle)
//  p_req_addr   in  ADDR_W       request address, registered in the mailbox on accept
//  p_req_wdata  in  DATA_W       request write data
//  p_req_write  in  1            1 = write, 0 = read
//  p_req_sel    in  SEL_W        target slave index
//  p_resp_valid out 1            one-cycle response pulse to the mailbox
//  p_resp_rdata out DATA_W       read data; 0 for writes and errors
//  p_resp_err   out 2            00 OK, 01 PSLVERR, 10 timeout, 11 decode error
//  paddr        out ADDR_W       APB address
//  pwdata       out DATA_W       APB write data
//  pwrite       out 1            APB direction
//  psel         out NSLV         one-hot slave select
//  penable      out 1            APB enable
//  prdata       in  NSLV*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W]
//  pready       in  NSLV         per-slave ready
//  pslverr      in  NSLV         per-slave error
// BEHAVIOUR
//  Reset (async, preset=1):
//   - state = IDLE; all outputs 0; counters 0.
//   - A mailbox request left pending stays pending and is accepted after reset releases.
//  FSM states and transitions:
//   - IDLE: p_req_accept = p_req_valid. Accept -> LOAD.
//   - LOAD: register p_req_* into paddr/pwdata/pwrite and an internal sel.
//     - sel < NSLV -> SETUP.
//     - sel >= NSLV -> RESP with err=11; no psel asserted.
//   - SETUP: psel[sel]=1, penable=0; always -> ACCESS after one cycle.
//   - ACCESS: psel[sel]=1, penable=1; timeout counter increments each cycle.
//     - pready[sel]=1: capture prdata slice (reads only; writes give 0); err = pslverr[sel] ? 01 : 00; -> RESP.
//     - TIMEOUT!=0 and counter reaches TIMEOUT-1 without pready: err=10, rdata=0; -> RESP.
//     - pready and timeout in the same cycle: pready wins.
//   - RESP: p_resp_valid=1 for exactly one cycle; psel/penable=0; -> HOLD.
//   - HOLD: count RESP_HOLD cycles, p_req_accept=0; -> IDLE.
//  Outputs and timing:
//   - p_resp_rdata/p_resp_err hold their values until the next RESP.
//   - paddr/pwdata/pwrite hold their values between transfers.
//   - Minimum turnaround, zero-wait slave: accept to p_resp_valid = 4 cycles (LOAD, SETUP, ACCESS, RESP).
//   - Only pready/pslverr/prdata of the selected slave are observed; other slaves are ignored.
//   - No pipelining: a request is never accepted while a transfer is in progress.
//   - p_req_valid dropping after accept has no effect on the transfer.
// STRUCTURE
//  - Shared package ahb2apb_pkg: state enum (IDLE, LOAD, SETUP, ACCESS, RESP, HOLD) and err codes
//    (ERR_OK=2'b00, ERR_SLV=2'b01, ERR_TMO=2'b10, ERR_DEC=2'b11).
//  - No sub-module. The timeout and hold counters share one counter register sized $clog2(max(TIMEOUT,RESP_HOLD)+1).
// TESTING
//  1. Read sel=1 addr=0x10, slave 1 pready=1 in first ACCESS, prdata=0xCAFE0001
//     -> psel=4'b0010; p_resp_valid 4 cycles after accept; rdata=0xCAFE0001, err=00.
//  2. Write sel=0 wdata=0xA5A5A5A5, pready delayed 3 cycles, pslverr=1
//     -> pwrite=1 held through ACCESS; err=01, rdata=0.
//  3. Read sel=2, TIMEOUT=8, pready never asserted
//     -> penable high 8 cycles, then drops; err=10, rdata=0.
//  4. sel=5 with NSLV=4 -> no psel ever asserted; err=11 two cycles after accept.
//  5. Back-to-back p_req_valid -> second accept exactly RESP_HOLD+1 cycles after the first p_resp_valid.
//  6. preset asserted mid-ACCESS -> psel, penable and p_resp_valid go 0 immediately;
//     after release the next pending request is accepted from IDLE.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb2apb_pkg
//  Brief    : Shared FSM state encoding and response error codes for the
//             APB transfer sequencer.
//  Revision : 1.0
// ============================================================================
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4,
    HOLD   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_DEC = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_xfer_sequencer
//  Brief    : Drains the PCLK-side mailbox one request at a time and runs a
//             single APB SETUP/ACCESS transfer with a PREADY timeout.
//  Revision : 1.0
// ============================================================================
module apb_xfer_sequencer
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 3,
  parameter int NSLV      = 4,
  parameter int TIMEOUT   = 256,
  parameter int RESP_HOLD = 6
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   p_req_valid,
  output logic                   p_req_accept,
  input  logic [ADDR_W-1:0]      p_req_addr,
  input  logic [DATA_W-1:0]      p_req_wdata,
  input  logic                   p_req_write,
  input  logic [SEL_W-1:0]       p_req_sel,
  output logic                   p_resp_valid,
  output logic [DATA_W-1:0]      p_resp_rdata,
  output logic [1:0]             p_resp_err,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic                   pwrite,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);

  // One counter serves both the ACCESS timeout and the post-response hold.
  localparam int CNT_MAX = max_int(max_int(TIMEOUT, RESP_HOLD), 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((TIMEOUT   > 0) ? TIMEOUT   - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((RESP_HOLD > 0) ? RESP_HOLD - 1 : 0);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NSLV-1:0]     psel_q;
  logic                penable_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [1:0]          resp_err_q;

  logic [NSLV-1:0]     sel_oh_d;
  logic                sel_ok;
  logic                slv_ready;
  logic                slv_err;
  logic [DATA_W-1:0]   slv_rdata;

  // Out-of-range selects decode to all-zeros, which doubles as the decode error.
  always_comb begin
    sel_oh_d = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (int'(p_req_sel) == i) sel_oh_d[i] = 1'b1;
    end
  end

  assign sel_ok = |sel_oh_d;

  // The registered one-hot select is the internal slave index for the return path.
  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) slv_rdata = slv_rdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  assign slv_ready = |(pready & psel_q);
  assign slv_err   = |(pslverr & psel_q);

  assign p_req_accept = (state_q == IDLE) && p_req_valid && !preset;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p_req_valid) state_q <= LOAD;
        end
        LOAD: begin
          paddr_q  <= p_req_addr;
          pwdata_q <= p_req_wdata;
          pwrite_q <= p_req_write;
          cnt_q    <= '0;
          if (sel_ok) begin
            psel_q  <= sel_oh_d;
            state_q <= SETUP;
          end else begin
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_DEC;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (slv_ready) begin
            resp_rdata_q <= pwrite_q ? '0 : slv_rdata;
            resp_err_q   <= slv_err ? ERR_SLV : ERR_OK;
            resp_valid_q <= 1'b1;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_TMO;
            resp_valid_q <= 1'b1;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          cnt_q   <= '0;
          state_q <= (RESP_HOLD == 0) ? IDLE : HOLD;
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p_resp_valid = resp_valid_q;
  assign p_resp_rdata = resp_rdata_q;
  assign p_resp_err   = resp_err_q;
  assign paddr        = paddr_q;
  assign pwdata       = pwdata_q;
  assign pwrite       = pwrite_q;
  assign psel         = psel_q;
  assign penable      = penable_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_xfer_sequencer
//  Brief    : Directed and randomized transfers against a latency/response
//             model derived from the transfer rules.
//  Revision : 1.0
// ============================================================================
module tb_apb_xfer_sequencer;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int SEL_W     = 3;
  localparam int NSLV      = 4;
  localparam int TIMEOUT   = 8;
  localparam int RESP_HOLD = 6;

  logic                   pclk = 1'b0;
  logic                   preset;
  logic                   p_req_valid;
  logic                   p_req_accept;
  logic [ADDR_W-1:0]      p_req_addr;
  logic [DATA_W-1:0]      p_req_wdata;
  logic                   p_req_write;
  logic [SEL_W-1:0]       p_req_sel;
  logic                   p_resp_valid;
  logic [DATA_W-1:0]      p_resp_rdata;
  logic [1:0]             p_resp_err;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic                   pwrite;
  logic [NSLV-1:0]        psel;
  logic                   penable;
  logic [NSLV*DATA_W-1:0] prdata;
  logic [NSLV-1:0]        pready;
  logic [NSLV-1:0]        pslverr;

  int checks = 0;
  int errors = 0;
  logic [1:0]        last_err;
  logic [DATA_W-1:0] last_rd;

  apb_xfer_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
    .NSLV(NSLV), .TIMEOUT(TIMEOUT), .RESP_HOLD(RESP_HOLD)
  ) dut (
    .pclk(pclk), .preset(preset),
    .p_req_valid(p_req_valid), .p_req_accept(p_req_accept),
    .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata),
    .p_req_write(p_req_write), .p_req_sel(p_req_sel),
    .p_resp_valid(p_resp_valid), .p_resp_rdata(p_resp_rdata), .p_resp_err(p_resp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Selected slave gets the scripted response; every other slave is random noise.
  task automatic drive_slaves(input int sel, input bit rdy, input bit serr, input logic [31:0] rdv);
    for (int i = 0; i < NSLV; i++) begin
      if (i == sel) begin
        pready[i]              = rdy;
        pslverr[i]             = serr;
        prdata[i*DATA_W +: DATA_W] = rdv;
      end else begin
        pready[i]              = 1'($urandom_range(0, 1));
        pslverr[i]             = 1'($urandom_range(0, 1));
        prdata[i*DATA_W +: DATA_W] = $urandom;
      end
    end
  endtask

  // w = ACCESS cycle (0-based) in which the selected slave raises pready.
  task automatic do_xfer(input bit wr, input int sel, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdv, input int w,
                         input bit serr, input int exp_idx, input bit pre_acc);
    int idx, extra, got_lat, exp_lat, exp_pen, pen_cnt, sel_cnt, bad, bus_bad, acc_bad;
    logic [1:0]  exp_err, got_err;
    logic [31:0] exp_rd, got_rd;
    logic [3:0]  oh;
    bit dec;

    dec = (sel >= NSLV);
    oh  = '0;
    if (!dec) oh[sel] = 1'b1;
    if (dec) begin
      exp_lat = 2; exp_err = 2'b11; exp_rd = '0; exp_pen = 0;
    end else if (w < TIMEOUT) begin
      exp_lat = 4 + w; exp_err = serr ? 2'b01 : 2'b00; exp_rd = wr ? 32'd0 : rdv; exp_pen = w + 1;
    end else begin
      exp_lat = 3 + TIMEOUT; exp_err = 2'b10; exp_rd = '0; exp_pen = TIMEOUT;
    end

    idx = 0; extra = 0;
    if (!pre_acc) tick();
    p_req_valid = 1'b1; p_req_addr = addr; p_req_wdata = wd;
    p_req_write = wr; p_req_sel = 3'(sel);
    drive_slaves(sel, 1'b0, serr, rdv);
    #1;
    if (p_resp_valid) extra++;
    while (!p_req_accept && idx < 40) begin
      tick();
      drive_slaves(sel, 1'b0, serr, rdv);
      #1;
      idx++;
      if (p_resp_valid) extra++;
    end
    check("accept_seen", 64'(p_req_accept), 64'd1);
    if (exp_idx >= 0) check("accept_gap", 64'(idx), 64'(exp_idx));
    check("resp_pulse_len", 64'(extra), 64'd0);
    check("held_err", 64'(p_resp_err), 64'(last_err));
    check("held_rdata", 64'(p_resp_rdata), 64'(last_rd));
    if (!p_req_accept) return;

    got_lat = -1; got_err = '0; got_rd = '0;
    pen_cnt = 0; sel_cnt = 0; bad = 0; bus_bad = 0; acc_bad = 0;
    for (int t = 1; t <= TIMEOUT + 12 && got_lat < 0; t++) begin
      tick();
      p_req_valid = 1'($urandom_range(0, 1));
      if (t >= 2) begin
        p_req_addr = $urandom; p_req_wdata = $urandom;
        p_req_write = 1'($urandom_range(0, 1)); p_req_sel = 3'($urandom_range(0, 7));
      end
      drive_slaves(sel, (!dec && w < TIMEOUT && t == 3 + w), serr, rdv);
      #1;
      if (p_req_accept) acc_bad++;
      if (penable) pen_cnt++;
      if (!dec && psel == oh) sel_cnt++;
      if (psel != 4'd0 && psel != oh) bad++;
      if (penable && psel == 4'd0) bad++;
      if (psel != 4'd0 && (paddr !== addr || pwdata !== wd || pwrite !== wr)) bus_bad++;
      if (p_resp_valid) begin
        got_lat = t; got_err = p_resp_err; got_rd = p_resp_rdata;
      end
    end
    p_req_valid = 1'b0;

    check("latency", 64'(got_lat), 64'(exp_lat));
    check("resp_err", 64'(got_err), 64'(exp_err));
    check("resp_rdata", 64'(got_rd), 64'(exp_rd));
    check("penable_cycles", 64'(pen_cnt), 64'(exp_pen));
    check("psel_cycles", 64'(sel_cnt), dec ? 64'd0 : 64'(exp_pen + 1));
    check("psel_illegal", 64'(bad), 64'd0);
    check("apb_bus_hold", 64'(bus_bad), 64'd0);
    check("accept_busy", 64'(acc_bad), 64'd0);
    last_err = exp_err;
    last_rd  = exp_rd;
  endtask

  initial begin
    int n;
    preset = 1'b1;
    p_req_valid = 1'b1; p_req_addr = 32'h10; p_req_wdata = '0;
    p_req_write = 1'b0; p_req_sel = 3'd1;
    pready = '0; pslverr = '0; prdata = '0;
    last_err = 2'b00; last_rd = '0;

    repeat (3) tick();
    #1;
    check("rst_accept", 64'(p_req_accept), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_resp_valid", 64'(p_resp_valid), 64'd0);
    check("rst_resp_err", 64'(p_resp_err), 64'd0);
    check("rst_resp_rdata", 64'(p_resp_rdata), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);

    // Pending request across reset is taken as soon as reset releases.
    tick();
    preset = 1'b0;
    do_xfer(1'b0, 1, 32'h10, 32'h0, 32'hCAFE0001, 0, 1'b0, 0, 1'b1);
    do_xfer(1'b1, 0, $urandom, 32'hA5A5A5A5, $urandom, 3, 1'b1, RESP_HOLD, 1'b0);
    do_xfer(1'b0, 2, $urandom, $urandom, $urandom, TIMEOUT + 5, 1'b0, RESP_HOLD, 1'b0);
    do_xfer(1'b0, 5, $urandom, $urandom, $urandom, 0, 1'b0, RESP_HOLD, 1'b0);
    do_xfer(1'b0, 3, $urandom, $urandom, 32'h5EED0003, TIMEOUT - 1, 1'b1, RESP_HOLD, 1'b0);

    // Reset in the middle of ACCESS.
    n = 0;
    tick();
    p_req_valid = 1'b1; p_req_addr = $urandom; p_req_sel = 3'd2; p_req_write = 1'b0;
    pready = '0; pslverr = '0;
    #1;
    while (!p_req_accept && n < 20) begin
      tick(); #1; n++;
    end
    check("mid_accept", 64'(p_req_accept), 64'd1);
    tick(); p_req_valid = 1'b0;
    tick(); #1;
    check("mid_setup_psel", 64'(psel), 64'b0100);
    check("mid_setup_penable", 64'(penable), 64'd0);
    tick(); #1;
    check("mid_access_penable", 64'(penable), 64'd1);
    p_req_valid = 1'b1;
    preset = 1'b1;
    #1;
    check("mid_rst_psel", 64'(psel), 64'd0);
    check("mid_rst_penable", 64'(penable), 64'd0);
    check("mid_rst_resp_valid", 64'(p_resp_valid), 64'd0);
    check("mid_rst_accept", 64'(p_req_accept), 64'd0);
    last_err = 2'b00; last_rd = '0;
    tick(); tick();
    preset = 1'b0;
    do_xfer(1'b0, 3, $urandom, $urandom, $urandom, 2, 1'b0, 0, 1'b1);

    for (int k = 0; k < 24; k++) begin
      do_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, int'($urandom_range(0, TIMEOUT + 1)), 1'($urandom_range(0, 1)),
              RESP_HOLD, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
